prog_loader: RTL and testbench

Parametrised program-memory loader and processor-release sequencer for the single-cycle MIPS core. Optionally zero-fills instruction memory, then writes a stream of instruction words at sequential addresses over a valid/ready handshake. After the last word it holds the core in clear for a programmable number of cycles and releases it to run. It sits between the host/test-stimulus side and the core's program-memory write port and clear input.

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader_if.sv | 14 +
 rtl/prog_loader.sv | 163 ++++++++++++++++
 tb/tb_prog_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and default widths for the MIPS program-memory loader.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ZERO    = 3'd1,
      ST_LOAD    = 3'd2,
      ST_RELEASE = 3'd3,
      ST_RUN     = 3'd4,
      ST_ERR     = 3'd5
   } loader_state_t;

   localparam int unsigned DEF_ADDR_W        = 8;
   localparam int unsigned DEF_DATA_W        = 32;
   localparam int unsigned DEF_CLEAR_ON_LOAD = 1;
   localparam int unsigned DEF_CLR_CYCLES    = 2;

endpackage

// File: rtl/prog_loader_if.sv
// Instruction-word stream from the host into the loader (valid/ready handshake).
interface prog_loader_if
   import prog_loader_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
);
   logic              word_valid;
   logic [DATA_W-1:0] word_data;
   logic              word_last;
   logic              word_ready;

   modport master (output word_valid, word_data, word_last, input word_ready);
   modport slave  (input word_valid, word_data, word_last, output word_ready);
endinterface

// File: rtl/prog_loader.sv
// Program-memory loader: optional zero-fill, sequential word load, then timed
// release of the core from clear.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned ADDR_W        = DEF_ADDR_W,
   parameter int unsigned DATA_W        = DEF_DATA_W,
   parameter int unsigned CLEAR_ON_LOAD = DEF_CLEAR_ON_LOAD,
   parameter int unsigned CLR_CYCLES    = DEF_CLR_CYCLES
) (
   input  logic                clk,
   input  logic                clr_n,
   input  logic                start,
   input  logic                halt,
   prog_loader_if.slave        word_if,
   output logic                prog_w,
   output logic [ADDR_W-1:0]   prog_addr,
   output logic [DATA_W-1:0]   prog_data,
   output logic                cpu_clr,
   output logic                cpu_run,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [ADDR_W:0]     word_count
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned REL_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

   loader_state_t     state_q, state_d;
   logic              prog_w_q, prog_w_d;
   logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
   logic [DATA_W-1:0] prog_data_q, prog_data_d;
   logic [CNT_W-1:0]  word_count_q, word_count_d;
   logic [REL_W-1:0]  rel_cnt_q, rel_cnt_d;
   logic              word_ready_q, word_ready_d;
   logic              cpu_clr_q, cpu_clr_d;
   logic              cpu_run_q, cpu_run_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              xfer_c;
   logic              restart_c;

   // Next-state, memory-write and counter logic; prog_addr doubles as the zero-fill pointer.
   always_comb begin
      state_d      = state_q;
      prog_w_d     = 1'b0;
      prog_addr_d  = prog_addr_q;
      prog_data_d  = prog_data_q;
      word_count_d = word_count_q;
      rel_cnt_d    = rel_cnt_q;
      restart_c    = 1'b0;
      xfer_c       = word_if.word_valid && word_ready_q;

      unique case (state_q)
         ST_IDLE: restart_c = start;
         ST_ZERO: begin
            if (prog_addr_q == ADDR_W'(DEPTH - 1)) begin
               state_d = ST_LOAD;
            end else begin
               prog_w_d    = 1'b1;
               prog_addr_d = prog_addr_q + ADDR_W'(1);
            end
         end
         ST_LOAD: begin
            if (xfer_c) begin
               prog_w_d     = 1'b1;
               prog_addr_d  = word_count_q[ADDR_W-1:0];
               prog_data_d  = word_if.word_data;
               word_count_d = word_count_q + CNT_W'(1);
               if (word_if.word_last) begin
                  state_d   = ST_RELEASE;
                  rel_cnt_d = '0;
               end else if (word_count_q == CNT_W'(DEPTH - 1)) begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_RELEASE: begin
            if (rel_cnt_q == REL_W'(CLR_CYCLES - 1)) begin
               state_d = ST_RUN;
            end else begin
               rel_cnt_d = rel_cnt_q + REL_W'(1);
            end
         end
         ST_RUN: begin
            if (halt) begin
               state_d = ST_IDLE;
            end else begin
               restart_c = start;
            end
         end
         ST_ERR:  restart_c = start;
         default: state_d = ST_IDLE;
      endcase

      if (restart_c) begin
         word_count_d = '0;
         if (CLEAR_ON_LOAD != 0) begin
            state_d     = ST_ZERO;
            prog_w_d    = 1'b1;
            prog_addr_d = '0;
            prog_data_d = '0;
         end else begin
            state_d = ST_LOAD;
         end
      end
   end

   // Status outputs follow the next state so they line up with the registered state.
   always_comb begin
      word_ready_d = (state_d == ST_LOAD);
      busy_d       = (state_d == ST_ZERO) || (state_d == ST_LOAD) || (state_d == ST_RELEASE);
      done_d       = (state_d == ST_RUN);
      err_d        = (state_d == ST_ERR);
      cpu_run_d    = (state_d == ST_RUN);
      cpu_clr_d    = (state_d != ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state_q      <= ST_IDLE;
         prog_w_q     <= 1'b0;
         prog_addr_q  <= '0;
         prog_data_q  <= '0;
         word_count_q <= '0;
         rel_cnt_q    <= '0;
         word_ready_q <= 1'b0;
         cpu_clr_q    <= 1'b1;
         cpu_run_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         prog_w_q     <= prog_w_d;
         prog_addr_q  <= prog_addr_d;
         prog_data_q  <= prog_data_d;
         word_count_q <= word_count_d;
         rel_cnt_q    <= rel_cnt_d;
         word_ready_q <= word_ready_d;
         cpu_clr_q    <= cpu_clr_d;
         cpu_run_q    <= cpu_run_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign word_if.word_ready = word_ready_q;
   assign prog_w             = prog_w_q;
   assign prog_addr          = prog_addr_q;
   assign prog_data          = prog_data_q;
   assign cpu_clr            = cpu_clr_q;
   assign cpu_run            = cpu_run_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign err                = err_q;
   assign word_count         = word_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: timestamp-based behavioural model checked every cycle,
// plus directed sequences with literal expectations.
module tb_prog_loader;

   localparam int ADDR_W     = 3;
   localparam int DATA_W     = 32;
   localparam int DEPTH      = 8;
   localparam int CLR_CYCLES = 2;

   localparam int M_IDLE = 0, M_ZERO = 1, M_LOAD = 2, M_REL = 3, M_RUN = 4, M_ERR = 5;

   logic              clk = 1'b0;
   logic              clr_n, start, halt;
   logic              prog_w;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_data;
   logic              cpu_clr, cpu_run, busy, done, err;
   logic [ADDR_W:0]   word_count;

   int n_tests = 0;
   int n_fail  = 0;

   prog_loader_if #(.DATA_W(DATA_W)) wif ();

   prog_loader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_ON_LOAD(1), .CLR_CYCLES(CLR_CYCLES)
   ) dut (
      .clk(clk), .clr_n(clr_n), .start(start), .halt(halt), .word_if(wif),
      .prog_w(prog_w), .prog_addr(prog_addr), .prog_data(prog_data),
      .cpu_clr(cpu_clr), .cpu_run(cpu_run), .busy(busy), .done(done), .err(err),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   // Program memory as seen by the core.
   logic [DATA_W-1:0] core_mem [DEPTH];
   always @(posedge clk) if (prog_w) core_mem[prog_addr] <= prog_data;

   // Model: mode plus the edge index at which it was entered.
   int                m_mode = M_IDLE;
   int                m_t0 = 0;
   int                m_count = 0;
   int                cyc = 0;
   bit                m_ok = 1'b0;
   logic              m_w = 1'b0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [DATA_W-1:0] m_data = '0;
   logic [DATA_W-1:0] m_mem [DEPTH];

   always @(posedge clk) begin
      int nmode, nt0, ncnt;
      logic nw;
      logic [ADDR_W-1:0] na;
      logic [DATA_W-1:0] nd;
      bit rs;
      nmode = m_mode; nt0 = m_t0; ncnt = m_count;
      nw = 1'b0; na = m_addr; nd = m_data; rs = 1'b0;
      if (!clr_n) begin
         nmode = M_IDLE; ncnt = 0; na = '0; nd = '0;
         m_ok <= 1'b1;
      end else begin
         case (m_mode)
            M_IDLE: rs = start;
            M_ZERO: begin
               if (cyc - m_t0 == DEPTH) nmode = M_LOAD;
               else begin nw = 1'b1; na = ADDR_W'(cyc - m_t0); nd = '0; end
            end
            M_LOAD: begin
               if (wif.word_valid) begin
                  nw = 1'b1; na = ADDR_W'(m_count); nd = wif.word_data;
                  m_mem[m_count] <= wif.word_data;
                  ncnt = m_count + 1;
                  if (wif.word_last) begin nmode = M_REL; nt0 = cyc; end
                  else if (ncnt == DEPTH) nmode = M_ERR;
               end
            end
            M_REL: if (cyc - m_t0 == CLR_CYCLES) nmode = M_RUN;
            M_RUN: begin
               if (halt) nmode = M_IDLE;
               else rs = start;
            end
            default: rs = start;
         endcase
         if (rs) begin
            nmode = M_ZERO; nt0 = cyc; ncnt = 0; nw = 1'b1; na = '0; nd = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
         end
      end
      m_mode  <= nmode;
      m_t0    <= nt0;
      m_count <= ncnt;
      m_w     <= nw;
      m_addr  <= na;
      m_data  <= nd;
      cyc     <= cyc + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_ok) begin
         chk("m_word_ready", 64'(wif.word_ready), 64'(m_mode == M_LOAD));
         chk("m_busy", 64'(busy), 64'(m_mode == M_ZERO || m_mode == M_LOAD || m_mode == M_REL));
         chk("m_done", 64'(done), 64'(m_mode == M_RUN));
         chk("m_err", 64'(err), 64'(m_mode == M_ERR));
         chk("m_cpu_run", 64'(cpu_run), 64'(m_mode == M_RUN));
         chk("m_cpu_clr", 64'(cpu_clr), 64'(m_mode != M_RUN));
         chk("m_word_count", 64'(word_count), 64'(m_count));
         chk("m_prog_w", 64'(prog_w), 64'(m_w));
         if (m_w) begin
            chk("m_prog_addr", 64'(prog_addr), 64'(m_addr));
            chk("m_prog_data", 64'(prog_data), 64'(m_data));
         end
      end
   end

   task automatic chk_mem();
      for (int i = 0; i < DEPTH; i++)
         chk($sformatf("mem%0d", i), 64'(core_mem[i]), 64'(m_mem[i]));
   endtask

   task automatic wait_ready(input int budget);
      int n = 0;
      while (wif.word_ready !== 1'b1 && n < budget) begin @(negedge clk); n++; end
      chk("wait_ready", 64'(wif.word_ready), 64'(1));
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
      chk("wait_done", 64'(done), 64'(1));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   bit          vv   [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   logic [31:0] tdat [4] = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};

   initial begin
      int k;
      clr_n = 1'b0; start = 1'b0; halt = 1'b0;
      wif.word_valid = 1'b0; wif.word_data = '0; wif.word_last = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_cpu_clr", 64'(cpu_clr), 64'(1));
      chk("rst_word_count", 64'(word_count), 64'(0));
      chk("rst_prog_w", 64'(prog_w), 64'(0));
      chk("rst_cpu_run", 64'(cpu_run), 64'(0));
      clr_n = 1'b1;
      @(negedge clk);

      // Zero-fill: DEPTH writes of 0 at ascending addresses, then ready.
      pulse_start();
      for (int i = 0; i < DEPTH; i++) begin
         chk("zero_w", 64'(prog_w), 64'(1));
         chk("zero_addr", 64'(prog_addr), 64'(i));
         chk("zero_data", 64'(prog_data), 64'(0));
         chk("zero_ready", 64'(wif.word_ready), 64'(0));
         @(negedge clk);
      end
      chk("ready_rise", 64'(wif.word_ready), 64'(1));
      chk("ready_rise_w", 64'(prog_w), 64'(0));

      // Three back-to-back words, last on the third.
      wif.word_valid = 1'b1; wif.word_data = 32'h20080005;
      @(negedge clk);
      chk("w0_addr", 64'(prog_addr), 64'(0));
      wif.word_data = 32'h20090003;
      @(negedge clk);
      wif.word_data = 32'h01095020; wif.word_last = 1'b1;
      @(negedge clk);
      wif.word_valid = 1'b0; wif.word_last = 1'b0;
      chk("last_count", 64'(word_count), 64'(3));
      chk("last_addr", 64'(prog_addr), 64'(2));
      chk("rel1_clr", 64'(cpu_clr), 64'(1));
      @(negedge clk);
      chk("rel2_clr", 64'(cpu_clr), 64'(1));
      chk("rel2_run", 64'(cpu_run), 64'(0));
      @(negedge clk);
      chk("run_run", 64'(cpu_run), 64'(1));
      chk("run_done", 64'(done), 64'(1));
      chk("run_clr", 64'(cpu_clr), 64'(0));
      @(negedge clk);
      chk("mem0_lit", 64'(core_mem[0]), 64'(32'h20080005));
      chk("mem1_lit", 64'(core_mem[1]), 64'(32'h20090003));
      chk("mem2_lit", 64'(core_mem[2]), 64'(32'h01095020));
      chk("mem3_lit", 64'(core_mem[3]), 64'(0));
      chk_mem();

      // Restart from RUN; gapped valid, stray last/start while not transferring.
      pulse_start();
      chk("restart_busy", 64'(busy), 64'(1));
      wait_ready(20);
      k = 0;
      for (int i = 0; i < 7; i++) begin
         wif.word_valid = vv[i];
         if (vv[i]) begin
            wif.word_data = tdat[k]; wif.word_last = (k == 3); k++;
         end else begin
            wif.word_data = 32'hBAD00000 + 32'(i); wif.word_last = 1'b1;
         end
         start = (i == 4);
         @(negedge clk);
      end
      start = 1'b0; wif.word_valid = 1'b0; wif.word_last = 1'b0;
      chk("gap_count", 64'(word_count), 64'(4));
      wait_done(10);
      @(negedge clk);
      chk("gap_mem1", 64'(core_mem[1]), 64'(32'hA0000002));
      chk("gap_mem3", 64'(core_mem[3]), 64'(32'hA0000004));
      chk("gap_mem4", 64'(core_mem[4]), 64'(0));
      chk_mem();

      // halt wins over start in RUN; halt alone in IDLE is ignored.
      halt = 1'b1; start = 1'b1;
      @(negedge clk);
      halt = 1'b0; start = 1'b0;
      chk("halt_run", 64'(cpu_run), 64'(0));
      chk("halt_clr", 64'(cpu_clr), 64'(1));
      chk("halt_done", 64'(done), 64'(0));
      chk("halt_busy", 64'(busy), 64'(0));
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      chk("idle_halt_busy", 64'(busy), 64'(0));

      // Overflow: DEPTH words without last.
      pulse_start();
      wait_ready(20);
      for (int i = 0; i < DEPTH; i++) begin
         wif.word_valid = 1'b1; wif.word_data = 32'h10000000 + 32'(i); wif.word_last = 1'b0;
         @(negedge clk);
      end
      chk("ovf_err", 64'(err), 64'(1));
      chk("ovf_ready", 64'(wif.word_ready), 64'(0));
      chk("ovf_run", 64'(cpu_run), 64'(0));
      chk("ovf_count", 64'(word_count), 64'(8));
      chk("ovf_addr", 64'(prog_addr), 64'(7));
      @(negedge clk);
      wif.word_valid = 1'b0;
      chk("err_no_write", 64'(prog_w), 64'(0));
      chk("err_hold", 64'(err), 64'(1));
      pulse_start();
      chk("err_clear", 64'(err), 64'(0));
      chk("err_restart_busy", 64'(busy), 64'(1));

      // Reset in the middle of a load.
      wait_ready(20);
      wif.word_valid = 1'b1; wif.word_data = 32'h00000055;
      @(negedge clk);
      wif.word_data = 32'h00000066;
      @(negedge clk);
      clr_n = 1'b0; wif.word_data = 32'h00000077;
      @(negedge clk);
      clr_n = 1'b1; wif.word_valid = 1'b0;
      chk("mid_rst_count", 64'(word_count), 64'(0));
      chk("mid_rst_ready", 64'(wif.word_ready), 64'(0));
      chk("mid_rst_w", 64'(prog_w), 64'(0));
      chk("mid_rst_clr", 64'(cpu_clr), 64'(1));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      repeat (2) @(negedge clk);
      chk("partial_mem0", 64'(core_mem[0]), 64'(32'h00000055));
      chk("partial_mem1", 64'(core_mem[1]), 64'(32'h00000066));
      chk("partial_mem2", 64'(core_mem[2]), 64'(0));
      chk_mem();

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
